decrypt_core: RTL and testbench

- Streaming byte decrypter; the receive-side inverse of the team's encrypter.
- Encryption of byte n in a frame is defined as C = PERM(D) XOR KEY[n mod 3].
  - KEY sequence: XOR_KEY1, XOR_KEY2, XOR_KEY3, repeating.
  - PERM: out bit i = in bit PERM_i.
- Decryption of byte n is therefore D = PERM_INV(C XOR KEY[n mod 3]).
- Two-stage valid/ready pipeline between the link receiver and the plaintext consumer. Keys and permutation come from the encrypt_config package.

---
 rtl/decrypt_core_if.sv | 25 ++
 rtl/decrypt_core.sv | 164 ++++++++++++++++
 tb/tb_decrypt_core.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypt_core_if.sv
// decrypt_core_if: ciphertext-in / plaintext-out streaming bus for decrypt_core.
// The master drives bytes in and accepts plaintext. The slave is the decrypter.
interface decrypt_core_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic [1:0]        key_idx;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, key_idx
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, key_idx
  );
endinterface

// File: rtl/decrypt_core.sv
// decrypt_core: two-stage valid/ready streaming byte decrypter.
// Byte n of a frame decrypts as D = PERM_INV(C ^ KEY[n mod 3]).
// Stage 1 applies the rotating XOR key, and stage 2 undoes the bit permutation.
// Optional macro DECRYPT_CFG_EN adds writable key registers (cfg_we/cfg_sel/cfg_key).
package encrypt_config;
  localparam logic [7:0] XOR_KEY1 = 8'hDE;
  localparam logic [7:0] XOR_KEY2 = 8'hAD;
  localparam logic [7:0] XOR_KEY3 = 8'hBE;
  // Encrypt permutation: ciphertext bit i = plaintext bit PERM_i
  localparam int unsigned PERM_0 = 7;
  localparam int unsigned PERM_1 = 6;
  localparam int unsigned PERM_2 = 5;
  localparam int unsigned PERM_3 = 4;
  localparam int unsigned PERM_4 = 3;
  localparam int unsigned PERM_5 = 2;
  localparam int unsigned PERM_6 = 1;
  localparam int unsigned PERM_7 = 0;
endpackage

module decrypt_core
  import encrypt_config::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned KEY_CNT = 3
) (
  input  logic             clk,
  input  logic             n_rst,
`ifdef DECRYPT_CFG_EN
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [7:0]       cfg_key,
`endif
  decrypt_core_if.slave    bus
);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("decrypt_core: DATA_W must be 8");
  end
  if (KEY_CNT < 1 || KEY_CNT > 3) begin : g_bad_key_cnt
    $error("decrypt_core: KEY_CNT must be 1..3");
  end

  localparam logic [1:0] LAST_IDX = 2'(KEY_CNT - 1);
  localparam logic [2:0] PERM [8] = '{3'(PERM_0), 3'(PERM_1), 3'(PERM_2), 3'(PERM_3),
                                      3'(PERM_4), 3'(PERM_5), 3'(PERM_6), 3'(PERM_7)};

  logic [DATA_W-1:0] w_keys [3];
  logic [1:0]        w_key_sel;
  logic [DATA_W-1:0] w_key;
  logic [DATA_W-1:0] w_plain;
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_sof;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sof;
  logic [1:0]        r_key_idx;

`ifdef DECRYPT_CFG_EN
  logic [DATA_W-1:0] r_keys [3];

  // Writable key bank; an accept in the write cycle still sees the old value
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_keys[0] <= XOR_KEY1;
      r_keys[1] <= XOR_KEY2;
      r_keys[2] <= XOR_KEY3;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    r_keys[0] <= cfg_key;
        2'd1:    r_keys[1] <= cfg_key;
        2'd2:    r_keys[2] <= cfg_key;
        default: ;
      endcase
    end
  end

  assign w_keys[0] = r_keys[0];
  assign w_keys[1] = r_keys[1];
  assign w_keys[2] = r_keys[2];
`else
  assign w_keys[0] = XOR_KEY1;
  assign w_keys[1] = XOR_KEY2;
  assign w_keys[2] = XOR_KEY3;
`endif

  // Handshake: a stage may load when it is empty or its content moves on
  assign w_s2_adv     = !r_out_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign w_accept     = bus.in_valid && w_s1_adv;
  assign bus.in_ready = w_s1_adv;

  // Key selection: start of frame always restarts at the first key
  always_comb begin
    w_key_sel = bus.in_sof ? 2'd0 : r_key_idx;
    w_key     = w_keys[0];
    case (w_key_sel)
      2'd1:    w_key = w_keys[1];
      2'd2:    w_key = w_keys[2];
      default: w_key = w_keys[0];
    endcase
  end

  // Inverse permutation: plaintext bit PERM_i is taken from stage-1 bit i
  always_comb begin
    w_plain = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_plain[PERM[i]] = r_s1_data[i];
    end
  end

  // Stage 1: XOR with the rotating key on accept
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sof   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= bus.in_data ^ w_key;
        r_s1_sof  <= bus.in_sof;
      end
    end
  end

  // Stage 2: permute into the output register; held while stalled
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_plain;
      r_out_sof   <= r_s1_sof;
    end
  end

  // Key index for the next accepted byte, wrapping after the last key
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_key_idx <= '0;
    end else if (w_accept) begin
      if (bus.in_sof) begin
        r_key_idx <= 2'd1;
      end else if (r_key_idx == LAST_IDX) begin
        r_key_idx <= '0;
      end else begin
        r_key_idx <= r_key_idx + 2'd1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sof   = r_out_sof;
  assign bus.key_idx   = r_key_idx;

endmodule

// File: tb/tb_decrypt_core.sv
// tb_decrypt_core: vector tables plus randomized traffic against a queue-based reference.
module tb_decrypt_core;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  decrypt_core_if #(.DATA_W(8)) bus ();

`ifdef DECRYPT_CFG_EN
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_key = '0;
`endif

  decrypt_core #(.DATA_W(8), .KEY_CNT(3)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
`ifdef DECRYPT_CFG_EN
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_key (cfg_key),
`endif
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes in flight (oldest first) and whether the oldest is presented
  logic [7:0] m_q  [$];
  logic       m_sq [$];
  logic       m_vis;
  logic [1:0] m_kidx;
  logic [7:0] m_key [3];
  logic       m_last_acc;
  logic       saw_stall;
  logic [7:0] got [$];

  typedef struct {
    logic       v;
    logic       sof;
    logic [7:0] d;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic [1:0] ek;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sq.delete();
    m_vis     = 1'b0;
    m_kidx    = 2'd0;
    m_key[0]  = 8'hDE;
    m_key[1]  = 8'hAD;
    m_key[2]  = 8'hBE;
  endtask

  // One clock: drive at posedge+1, check in_ready at negedge, check outputs at posedge+1
  task automatic cycle(input logic v, input logic s, input logic [7:0] d, input logic ordy);
    logic       exp_rdy;
    logic       acc;
    logic [1:0] k;
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    exp_rdy = (m_q.size() < 2) || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (bus.in_ready === 1'b0) saw_stall = 1'b1;
    if (bus.out_valid === 1'b1 && ordy) got.push_back(bus.out_data);
    acc = v && exp_rdy;
    if (!m_vis || ordy) begin
      if (m_vis) begin
        m_q.delete(0);
        m_sq.delete(0);
        m_vis = 1'b0;
      end
      if (m_q.size() > 0) m_vis = 1'b1;
    end
    if (acc) begin
      k = s ? 2'd0 : m_kidx;
      m_q.push_back(rev8(d ^ m_key[k]));
      m_sq.push_back(s);
      m_kidx = s ? 2'd1 : ((m_kidx == 2'd2) ? 2'd0 : m_kidx + 2'd1);
    end
`ifdef DECRYPT_CFG_EN
    if (cfg_we && cfg_sel != 2'd3) m_key[cfg_sel] = cfg_key;
`endif
    m_last_acc = acc;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_vis));
    chk("key_idx", 32'(bus.key_idx), 32'(m_kidx));
    if (m_vis) begin
      chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
      chk("out_sof", 32'(bus.out_sof), 32'(m_sq[0]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_got(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int n);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk({nm, "_byte"}, 32'(got[i]), 32'(e[i]));
  endtask

  initial begin
    logic [7:0] bp_d [4];
    int         bi;
    int         stall_left;
    logic       first;
    logic       ordy;

    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    saw_stall = 1'b0; m_last_acc = 1'b0;
    model_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_out_sof", 32'(bus.out_sof), 32'd0);
    chk("rst_key_idx", 32'(bus.key_idx), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Vector table: plain frame, mid-frame sof, idle gap (all with out_ready=1)
    tbl.push_back('{1, 1, 8'hDE, 1, 0, 8'h00, 0, 2'd1});
    tbl.push_back('{1, 0, 8'h2D, 1, 1, 8'h00, 1, 2'd2});
    tbl.push_back('{1, 0, 8'hBF, 1, 1, 8'h01, 0, 2'd0});
    tbl.push_back('{1, 0, 8'hDF, 1, 1, 8'h80, 0, 2'd1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h80, 0, 2'd1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd1});
    tbl.push_back('{1, 1, 8'hDE, 1, 0, 8'h00, 0, 2'd1});
    tbl.push_back('{1, 0, 8'h2D, 1, 1, 8'h00, 1, 2'd2});
    tbl.push_back('{1, 1, 8'hDF, 1, 1, 8'h01, 0, 2'd1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h80, 1, 2'd1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd1});
    tbl.push_back('{1, 1, 8'hDE, 1, 0, 8'h00, 0, 2'd1});
    tbl.push_back('{1, 0, 8'h2D, 1, 1, 8'h00, 1, 2'd2});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h01, 0, 2'd2});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd2});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd2});
    tbl.push_back('{1, 0, 8'hBF, 1, 0, 8'h00, 0, 2'd0});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h80, 0, 2'd0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 2'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].ordy);
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].ev));
      chk("tbl_key_idx", 32'(bus.key_idx), 32'(tbl[i].ek));
      if (tbl[i].ev) begin
        chk("tbl_out_data", 32'(bus.out_data), 32'(tbl[i].ed));
        chk("tbl_out_sof", 32'(bus.out_sof), 32'(tbl[i].es));
      end
    end

    // Backpressure: consumer stalls 5 cycles after the first out_valid
    bp_d[0] = 8'hDE; bp_d[1] = 8'h2D; bp_d[2] = 8'hBF; bp_d[3] = 8'hDF;
    got.delete(); saw_stall = 1'b0; bi = 0; stall_left = 0; first = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      ordy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (bi < 4) cycle(1'b1, bi == 0, bp_d[bi], ordy);
      else        cycle(1'b0, 1'b0, 8'h00, ordy);
      if (m_last_acc) bi++;
      if (!first && bus.out_valid === 1'b1) begin
        first = 1'b1;
        stall_left = 5;
      end
    end
    chk_got("bp", 8'h00, 8'h01, 8'h80, 8'h80, 4);
    chk("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
    idle(2);

    // Asynchronous reset with two bytes held in the pipeline
    cycle(1'b1, 1'b1, 8'hDE, 1'b0);
    cycle(1'b1, 1'b0, 8'h2D, 1'b0);
    n_rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_key_idx", 32'(bus.key_idx), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'h00);
    model_reset();
    #2;
    n_rst = 1'b1;
    got.delete();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'hDE, 1'b1);
    idle(3);
    chk_got("arst_after", 8'h00, 8'h00, 8'h00, 8'h00, 1);

`ifdef DECRYPT_CFG_EN
    // Write in the accept cycle uses the old key, then the new key applies
    got.delete();
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_key = 8'h00;
    cycle(1'b1, 1'b1, 8'hDE, 1'b1);
    cfg_we = 1'b0;
    cycle(1'b1, 1'b1, 8'h01, 1'b1);
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_key = 8'h55;
    cycle(1'b1, 1'b1, 8'h01, 1'b1);
    cfg_we = 1'b0;
    idle(3);
    chk_got("cfg", 8'h00, 8'h80, 8'h80, 8'h00, 3);
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
`ifdef DECRYPT_CFG_EN
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_key = 8'($urandom);
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0);
    end
`ifdef DECRYPT_CFG_EN
    cfg_we = 1'b0;
`endif
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
